// File: rtl/spram_ctl.sv
`default_nettype none
// ============================================================================
// Module  : spram_ctl
// Brief   : Byte/half/word valid-ready front end for one SP256K (16K x 16),
//           with idle-timed standby and a counted wake-up.
// Rev     : 1.0
// ============================================================================
module spram_ctl #(
  parameter int IDLE_SLEEP = 256,
  parameter int WAKE_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_sz,
  input  logic [14:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [13:0] ram_ad,
  output logic [15:0] ram_di,
  output logic [3:0]  ram_maskwe,
  output logic        ram_we,
  output logic        ram_cs,
  output logic        ram_stdby,
  output logic        ram_sleep,
  output logic        ram_pwroff_n,
  input  logic [15:0] ram_do
);

  localparam int IDLE_W = (IDLE_SLEEP > 1) ? $clog2(IDLE_SLEEP) : 1;
  localparam int WAKE_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACC0 = 3'd1,
    S_ACC1 = 3'd2,
    S_DONE = 3'd3,
    S_STBY = 3'd4,
    S_WAKE = 3'd5
  } state_t;

  state_t            state_q;
  logic              we_q;
  logic [1:0]        sz_q;
  logic              byte_hi_q;
  logic [15:0]       wdata_hi_q;
  logic [15:0]       rd_lo_q;
  logic              err_pend_q;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic [WAKE_W-1:0] wake_cnt_q;

  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [31:0]       rsp_rdata_q;
  logic [13:0]       ram_ad_q;
  logic [15:0]       ram_di_q;
  logic [3:0]        ram_maskwe_q;
  logic              ram_we_q;
  logic              ram_cs_q;
  logic              ram_stdby_q;

  logic              w_illegal;
  logic              w_accept;
  logic              w_sleep_due;
  logic [15:0]       w_di0;
  logic [3:0]        w_mask0;
  logic [31:0]       w_rd_final;

  assign req_ready   = !rst && (state_q == S_IDLE);
  assign w_accept    = req_valid && req_ready;
  assign w_illegal   = (req_sz == 2'd3) ||
                       (req_sz == 2'd1 && req_addr[0]) ||
                       (req_sz == 2'd2 && req_addr[1:0] != 2'b00);
  assign w_sleep_due = (IDLE_SLEEP != 0) && (idle_cnt_q == IDLE_W'(IDLE_SLEEP - 1));

  // First-beat data and nibble lanes; a byte is replicated so either lane sees it
  always_comb begin
    w_di0   = req_wdata[15:0];
    w_mask0 = 4'b1111;
    if (!req_we) begin
      w_di0   = 16'h0000;
      w_mask0 = 4'b0000;
    end else if (req_sz == 2'd0) begin
      w_di0   = {2{req_wdata[7:0]}};
      w_mask0 = req_addr[0] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    w_rd_final = {16'h0000, ram_do};
    case (sz_q)
      2'd0:    w_rd_final = {24'h000000, byte_hi_q ? ram_do[15:8] : ram_do[7:0]};
      2'd2:    w_rd_final = {ram_do, rd_lo_q};
      default: w_rd_final = {16'h0000, ram_do};
    endcase
    if (we_q) begin
      w_rd_final = 32'h0000_0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      sz_q         <= 2'd0;
      byte_hi_q    <= 1'b0;
      wdata_hi_q   <= 16'h0000;
      rd_lo_q      <= 16'h0000;
      err_pend_q   <= 1'b0;
      idle_cnt_q   <= '0;
      wake_cnt_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= 32'h0000_0000;
      ram_ad_q     <= 14'h0000;
      ram_di_q     <= 16'h0000;
      ram_maskwe_q <= 4'b0000;
      ram_we_q     <= 1'b0;
      ram_cs_q     <= 1'b0;
      ram_stdby_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      // Rejected requests answer one cycle late, while the FSM stays in IDLE
      if (err_pend_q) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 1'b1;
        rsp_rdata_q <= 32'h0000_0000;
        err_pend_q  <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            idle_cnt_q <= '0;
            if (w_illegal) begin
              err_pend_q <= 1'b1;
            end else begin
              we_q         <= req_we;
              sz_q         <= req_sz;
              byte_hi_q    <= req_addr[0];
              wdata_hi_q   <= req_wdata[31:16];
              ram_cs_q     <= 1'b1;
              ram_we_q     <= req_we;
              ram_ad_q     <= req_addr[14:1];
              ram_di_q     <= w_di0;
              ram_maskwe_q <= w_mask0;
              state_q      <= S_ACC0;
            end
          end else if (w_sleep_due) begin
            idle_cnt_q  <= '0;
            ram_stdby_q <= 1'b1;
            state_q     <= S_STBY;
          end else begin
            idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
          end
        end
        S_ACC0: begin
          if (sz_q == 2'd2) begin
            ram_ad_q     <= {ram_ad_q[13:1], 1'b1};
            ram_di_q     <= we_q ? wdata_hi_q : 16'h0000;
            ram_maskwe_q <= {4{we_q}};
            state_q      <= S_ACC1;
          end else begin
            ram_cs_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_maskwe_q <= 4'b0000;
            state_q      <= S_DONE;
          end
        end
        S_ACC1: begin
          if (!we_q) begin
            rd_lo_q <= ram_do;
          end
          ram_cs_q     <= 1'b0;
          ram_we_q     <= 1'b0;
          ram_maskwe_q <= 4'b0000;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= w_rd_final;
          state_q     <= S_IDLE;
        end
        S_STBY: begin
          if (req_valid) begin
            ram_stdby_q <= 1'b0;
            wake_cnt_q  <= '0;
            state_q     <= S_WAKE;
          end
        end
        S_WAKE: begin
          if (wake_cnt_q == WAKE_W'(WAKE_CYC - 1)) begin
            idle_cnt_q <= '0;
            state_q    <= S_IDLE;
          end else begin
            wake_cnt_q <= wake_cnt_q + WAKE_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign ram_ad       = ram_ad_q;
  assign ram_di       = ram_di_q;
  assign ram_maskwe   = ram_maskwe_q;
  assign ram_we       = ram_we_q;
  assign ram_cs       = ram_cs_q;
  assign ram_stdby    = ram_stdby_q;
  assign ram_sleep    = 1'b0;
  assign ram_pwroff_n = 1'b1;

endmodule
`default_nettype wire
